// File: rtl/debug_bus_responder_if.sv
// Debug bus carrying single-cycle read/write strobes and a registered read response.
interface debug_bus_responder_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        write_strobe;
    logic        read_strobe;
    logic [7:0]  rdata;
    logic        rdata_valid;

    modport master (
        output addr, wdata, write_strobe, read_strobe,
        input  rdata, rdata_valid
    );

    modport slave (
        input  addr, wdata, write_strobe, read_strobe,
        output rdata, rdata_valid
    );
endinterface

// File: rtl/debug_bus_responder.sv
// 16-byte debug register window: 12 control bytes, synchronized status, write pulse,
// access and dropped-read counters, serviced by a three-state read FSM.
module debug_bus_responder #(
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter logic [95:0] CTRL_RESET = 96'h0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    debug_bus_responder_if.slave         dbus,
    output logic [95:0]                  ctrl_out,
    input  logic [7:0]                   status_in,
    output logic [7:0]                   pulse_out
);
    typedef enum logic [1:0] {IDLE, CAPTURE, RESPOND} rd_state_t;

    rd_state_t  state_reg;
    logic [7:0] ctrl_reg [12];
    logic [7:0] sync1_reg;
    logic [7:0] sync2_reg;
    logic [7:0] pulse_reg;
    logic [7:0] acc_cnt_reg;
    logic [7:0] drop_cnt_reg;
    logic [3:0] off_reg;
    logic [7:0] cap_data_reg;
    logic [7:0] rdata_reg;
    logic       valid_reg;

    logic       hit;
    logic [3:0] offset;
    logic       wr_hit;
    logic       rd_accept;
    logic       rd_drop;
    logic [7:0] acc_inc;
    logic [7:0] snap_next;

    assign hit       = (dbus.addr[15:4] == BASE_ADDR[15:4]);
    assign offset    = dbus.addr[3:0];
    assign wr_hit    = dbus.write_strobe & hit;
    assign rd_accept = dbus.read_strobe & hit & (state_reg == IDLE);
    assign rd_drop   = dbus.read_strobe & hit & (state_reg != IDLE);
    assign acc_inc   = {7'd0, wr_hit} + {7'd0, rd_accept};

    // Control bytes and the drop counter are snapshotted at acceptance so a
    // coincident write to the same offset returns the pre-write value.
    always_comb begin
        snap_next = 8'h00;
        if (offset < 4'd12)
            snap_next = ctrl_reg[offset];
        else if (offset == 4'hF)
            snap_next = drop_cnt_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 12; i++)
                ctrl_reg[i] <= CTRL_RESET[8*i +: 8];
            sync1_reg    <= 8'h00;
            sync2_reg    <= 8'h00;
            pulse_reg    <= 8'h00;
            acc_cnt_reg  <= 8'h00;
            drop_cnt_reg <= 8'h00;
        end else begin
            sync1_reg   <= status_in;
            sync2_reg   <= sync1_reg;
            acc_cnt_reg <= acc_cnt_reg + acc_inc;
            pulse_reg   <= (wr_hit && offset == 4'hD) ? dbus.wdata : 8'h00;
            if (wr_hit && offset < 4'd12)
                ctrl_reg[offset] <= dbus.wdata;
            if (wr_hit && offset == 4'hF)
                drop_cnt_reg <= 8'h00;
            else if (rd_drop && drop_cnt_reg != 8'hFF)
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            off_reg      <= 4'h0;
            cap_data_reg <= 8'h00;
            rdata_reg    <= 8'h00;
            valid_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    valid_reg <= 1'b0;
                    if (rd_accept) begin
                        off_reg      <= offset;
                        cap_data_reg <= snap_next;
                        state_reg    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    case (off_reg)
                        4'hC:    rdata_reg <= sync2_reg;
                        4'hD:    rdata_reg <= 8'h00;
                        4'hE:    rdata_reg <= acc_cnt_reg;
                        default: rdata_reg <= cap_data_reg;
                    endcase
                    valid_reg <= 1'b1;
                    state_reg <= RESPOND;
                end
                RESPOND: begin
                    valid_reg <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    valid_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_ctrl
            assign ctrl_out[8*gi +: 8] = ctrl_reg[gi];
        end
    endgenerate

    assign pulse_out        = pulse_reg;
    assign dbus.rdata       = rdata_reg;
    assign dbus.rdata_valid = valid_reg;
endmodule

// File: tb/tb_debug_bus_responder.sv
// Directed bench for debug_bus_responder: vector table plus hand-written corner sequences.
module tb_debug_bus_responder;
    localparam logic [95:0] CTRL_RST = 96'h0B0A_0908_0706_0504_0302_0100;

    logic        clk;
    logic        rst_n;
    logic [95:0] ctrl_out;
    logic [7:0]  status_in;
    logic [7:0]  pulse_out;
    int          tests;
    int          fails;

    debug_bus_responder_if bus ();

    debug_bus_responder #(
        .BASE_ADDR (16'h0000),
        .CTRL_RESET(CTRL_RST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dbus     (bus),
        .ctrl_out (ctrl_out),
        .status_in(status_in),
        .pulse_out(pulse_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s: %h", name, act);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.write_strobe = 1'b0;
        bus.read_strobe  = 1'b0;
        #1;
        chk("rst_ctrl", ctrl_out, CTRL_RST);
        chk("rst_valid", {95'd0, bus.rdata_valid}, 96'd0);
        chk("rst_rdata", {88'd0, bus.rdata}, 96'd0);
        chk("rst_pulse", {88'd0, pulse_out}, 96'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        bus.addr = addr;
        bus.wdata = data;
        bus.write_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus.write_strobe = 1'b0;
        if (addr[15:4] == 12'h000 && addr[3:0] < 4'd12)
            chk("wr_ctrl", {88'd0, ctrl_out[8*int'(addr[3:0]) +: 8]}, {88'd0, data});
    endtask

    task automatic rd(input logic [15:0] addr, input logic [7:0] exp);
        bus.addr = addr;
        bus.read_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus.read_strobe = 1'b0;
        chk("rd_valid_n1", {95'd0, bus.rdata_valid}, 96'd0);
        @(posedge clk);
        #1;
        chk("rd_valid_n2", {95'd0, bus.rdata_valid}, 96'd1);
        chk("rd_data", {88'd0, bus.rdata}, {88'd0, exp});
        @(posedge clk);
        #1;
        chk("rd_valid_n3", {95'd0, bus.rdata_valid}, 96'd0);
        chk("rd_hold", {88'd0, bus.rdata}, {88'd0, exp});
    endtask

    initial begin
        int vcount;
        tests = 0;
        fails = 0;
        status_in = 8'h00;
        bus.addr = 16'h0;
        bus.wdata = 8'h0;
        bus.write_strobe = 1'b0;
        bus.read_strobe = 1'b0;
        rst_n = 1'b1;

        // Access counter value after each row noted on the right.
        vecs[0]  = '{1'b0, 16'h0003, 8'h00, 8'h03}; // 1
        vecs[1]  = '{1'b1, 16'h0003, 8'hA5, 8'h00}; // 2
        vecs[2]  = '{1'b0, 16'h0003, 8'h00, 8'hA5}; // 3
        vecs[3]  = '{1'b1, 16'h000B, 8'h5A, 8'h00}; // 4
        vecs[4]  = '{1'b0, 16'h000B, 8'h00, 8'h5A}; // 5
        vecs[5]  = '{1'b0, 16'h000E, 8'h00, 8'h06}; // 6
        vecs[6]  = '{1'b1, 16'h000E, 8'hFF, 8'h00}; // 7
        vecs[7]  = '{1'b0, 16'h000E, 8'h00, 8'h08}; // 8
        vecs[8]  = '{1'b0, 16'h000D, 8'h00, 8'h00}; // 9
        vecs[9]  = '{1'b0, 16'h000F, 8'h00, 8'h00}; // 10
        vecs[10] = '{1'b0, 16'h0000, 8'h00, 8'h00}; // 11

        #2;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
            else               rd(vecs[i].addr, vecs[i].exp);
        end

        // Write-triggered pulse lasts exactly one cycle.
        do_reset();
        wr(16'h000D, 8'h81);
        chk("pulse_on", {88'd0, pulse_out}, {88'd0, 8'h81});
        @(posedge clk);
        #1;
        chk("pulse_off", {88'd0, pulse_out}, 96'd0);
        rd(16'h000D, 8'h00);

        // Status through the synchronizer.
        status_in = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        rd(16'h000C, 8'h3C);

        // Three consecutive read strobes: one response, two drops.
        do_reset();
        vcount = 0;
        bus.addr = 16'h0001;
        bus.read_strobe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vcount += int'(bus.rdata_valid);
        end
        bus.read_strobe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            vcount += int'(bus.rdata_valid);
        end
        chk("b2b_responses", 96'(vcount), 96'd1);
        rd(16'h000E, 8'h02);
        rd(16'h000F, 8'h02);

        // Simultaneous read and write to the same offset returns the old value.
        do_reset();
        bus.addr = 16'h0005;
        bus.wdata = 8'h77;
        bus.write_strobe = 1'b1;
        bus.read_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus.write_strobe = 1'b0;
        bus.read_strobe = 1'b0;
        chk("rw_ctrl", {88'd0, ctrl_out[47:40]}, {88'd0, 8'h77});
        @(posedge clk);
        #1;
        chk("rw_valid", {95'd0, bus.rdata_valid}, 96'd1);
        chk("rw_data", {88'd0, bus.rdata}, {88'd0, 8'h05});
        @(posedge clk);
        #1;
        rd(16'h000E, 8'h03);

        // Access counter wraps after 260 writes.
        do_reset();
        bus.addr = 16'h0000;
        bus.wdata = 8'h11;
        bus.write_strobe = 1'b1;
        repeat (260) @(posedge clk);
        #1;
        bus.write_strobe = 1'b0;
        rd(16'h000E, 8'h05);

        // Dropped-read counter saturates, then a write clears it.
        bus.addr = 16'h0002;
        bus.read_strobe = 1'b1;
        repeat (460) @(posedge clk);
        #1;
        bus.read_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd(16'h000F, 8'hFF);
        wr(16'h000F, 8'h00);
        rd(16'h000F, 8'h00);

        // Accesses outside the window have no effect.
        do_reset();
        vcount = 0;
        wr(16'h0013, 8'hEE);
        bus.addr = 16'h0013;
        bus.read_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus.read_strobe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            vcount += int'(bus.rdata_valid);
        end
        chk("miss_valid", 96'(vcount), 96'd0);
        chk("miss_ctrl", ctrl_out, CTRL_RST);
        rd(16'h000E, 8'h01);
        rd(16'h000F, 8'h00);

        // Reset during CAPTURE aborts the read; next read is serviced.
        wr(16'h0003, 8'h99);
        bus.addr = 16'h0003;
        bus.read_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus.read_strobe = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_ctrl", ctrl_out, CTRL_RST);
        chk("abort_valid0", {95'd0, bus.rdata_valid}, 96'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vcount += int'(bus.rdata_valid);
        end
        chk("abort_no_valid", 96'(vcount), 96'd0);
        rd(16'h0003, 8'h03);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/debug_bus_responder.md
DEBUG_BUS_RESPONDER -- requirements
Module: debug_bus_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0000, meaning first address of the 16-byte register window; it SHALL be 16-aligned.
REQ-002 SHALL have parameter CTRL_RESET, default 96'h0, meaning reset image of control registers 0x0-0xB (byte n at bits 8n+7:8n).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic rises on its positive edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port dbus.addr, input, 16 bits: access address.
REQ-006 SHALL have port dbus.wdata, input, 8 bits: write data.
REQ-007 SHALL have port dbus.write_strobe, input, 1 bit: single-cycle write request.
REQ-008 SHALL have port dbus.read_strobe, input, 1 bit: single-cycle read request.
REQ-009 SHALL have port dbus.rdata, output, 8 bits: read response data.
REQ-010 SHALL have port dbus.rdata_valid, output, 1 bit: single-cycle read response qualifier.
REQ-011 SHALL have port ctrl_out, output, 96 bits: control registers 0x0-0xB.
REQ-012 SHALL have port status_in, input, 8 bits: asynchronous status bits.
REQ-013 SHALL have port pulse_out, output, 8 bits: write-triggered strobes.

Function
REQ-014 Hit SHALL be defined as addr[15:4] == BASE_ADDR[15:4]; offset = addr[3:0]; non-hit accesses SHALL cause no state change and no response.
REQ-015 Offsets 0x0-0xB SHALL be read/write control registers driving ctrl_out directly from flops.
REQ-016 Offset 0xC SHALL be read-only and return status_in after a two-flop synchronizer.
REQ-017 Offset 0xD SHALL be write-only: a write SHALL drive pulse_out = wdata for exactly the next cycle, otherwise 0; a read SHALL return 8'h00.
REQ-018 Offset 0xE SHALL be read-only: 8-bit access counter, +1 per accepted hit (read or write), wrapping 255 -> 0.
REQ-019 Offset 0xF SHALL be a dropped-read counter, +1 per dropped read, saturating at 255; any write SHALL clear it to 0.
REQ-020 Writes to read-only offsets (0xC, 0xE) SHALL be ignored but still counted in 0xE.
REQ-021 Writes SHALL take effect on the clock edge sampling write_strobe; ctrl_out SHALL show the new value the following cycle.
REQ-022 Read FSM SHALL have states IDLE, CAPTURE, RESPOND: IDLE -> CAPTURE on hit read (offset latched); CAPTURE -> RESPOND (data muxed into rdata register); RESPOND -> IDLE with rdata_valid = 1 for that one cycle.
REQ-023 Read latency SHALL be exactly 2 cycles: strobe at cycle N -> rdata_valid at cycle N+2.
REQ-024 A hit read arriving while the FSM is not IDLE SHALL be dropped: no response, 0xF incremented, 0xE not incremented.
REQ-025 A hit read in RESPOND's cycle SHALL also be dropped (no back-to-back acceptance faster than every 3 cycles).
REQ-026 Simultaneous read and write to the same hit offset SHALL return the pre-write value, apply the write, and increment 0xE by 2, wrapping.
REQ-027 Reads of 0xE/0xF SHALL return the counter value as sampled in CAPTURE, i.e. including the read's own increment to 0xE.
REQ-028 dbus.rdata SHALL hold its last value when rdata_valid = 0.

Reset
REQ-029 On rst_n = 0, asynchronously: FSM = IDLE, rdata = 0, rdata_valid = 0, pulse_out = 0, counters = 0, synchronizer = 0, control registers = CTRL_RESET.
REQ-030 Reset asserted mid-read SHALL abort the read with no rdata_valid afterwards; the first strobe after release SHALL be serviced normally.

Verification
REQ-031 Write 0xA5 to BASE+0x3, read BASE+0x3 -> ctrl_out[31:24] = 0xA5 one cycle after write; rdata = 0xA5, rdata_valid exactly 2 cycles after read strobe.
REQ-032 Write 0x81 to BASE+0xD -> pulse_out = 0x81 for one cycle, then 0x00; readback of 0xD = 0x00.
REQ-033 Read strobes on 3 consecutive cycles -> one response, 0xF reads 2, 0xE reads 2 (including that read).
REQ-034 260 accepted writes to BASE+0x0 then read 0xE -> 0x05 (wrap); 300 dropped reads -> 0xF = 0xFF; write 0xF -> 0x00.
REQ-035 Read/write to BASE+0x10 with BASE_ADDR = 0 -> no rdata_valid, ctrl_out and counters unchanged.
REQ-036 Drive status_in = 0x3C, read 0xC after 2+ cycles -> 0x3C; assert rst_n low in CAPTURE -> no rdata_valid, ctrl_out = CTRL_RESET.
